// File: rtl/sccb_pkg.sv
// Shared state type and OV7670 constants for the SCCB target.
package sccb_pkg;

  localparam logic [7:0]  OV7670_WR_ADDR = 8'h42;
  localparam logic [7:0]  OV7670_RD_ADDR = 8'h43;
  localparam int unsigned NUM_REGS       = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_SUB,
    ST_WR,
    ST_RD,
    ST_IGNORE
  } sccb_state_t;

endpackage

// File: rtl/sccb_target_if.sv
// Register-side port of the SCCB target: write strobe, debug read, busy flag.
interface sccb_target_if;

  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       busy;

  modport slave (
    output wr_valid, wr_addr, wr_data, dbg_data, busy,
    input  dbg_addr
  );

  modport master (
    input  wr_valid, wr_addr, wr_data, dbg_data, busy,
    output dbg_addr
  );

endinterface

// File: rtl/sccb_line_cond.sv
// SCL/SDA synchronizer and glitch filter with SCL edge and START/STOP pulses.
module sccb_line_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_lines,     // [1] = SCL, [0] = SDA
  output logic       o_sda,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic       o_start,
  output logic       o_stop
);

  logic [1:0][SYNC_STAGES-1:0] r_sync;
  logic [1:0][FILT_LEN-1:0]    r_hist;
  logic [1:0]                  r_level;
  logic [1:0]                  r_level_q;
  logic [1:0]                  w_all1;
  logic [1:0]                  w_all0;

  assign w_all1 = {&r_hist[1], &r_hist[0]};
  assign w_all0 = {~|r_hist[1], ~|r_hist[0]};

  // Idle bus is high on both lines, so everything resets to 1 to avoid false edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '1;
      r_hist    <= '1;
      r_level   <= '1;
      r_level_q <= '1;
    end else begin
      r_sync[1] <= {r_sync[1][SYNC_STAGES-2:0], i_lines[1]};
      r_sync[0] <= {r_sync[0][SYNC_STAGES-2:0], i_lines[0]};
      r_hist[1] <= {r_hist[1][FILT_LEN-2:0], r_sync[1][SYNC_STAGES-1]};
      r_hist[0] <= {r_hist[0][FILT_LEN-2:0], r_sync[0][SYNC_STAGES-1]};
      r_level   <= (r_level | w_all1) & ~w_all0;
      r_level_q <= r_level;
    end
  end

  assign o_sda      = r_level[0];
  assign o_scl_rise =  r_level[1] & ~r_level_q[1];
  assign o_scl_fall = ~r_level[1] &  r_level_q[1];
  assign o_start    =  r_level_q[0] & ~r_level[0] & r_level[1] & r_level_q[1];
  assign o_stop     = ~r_level_q[0] &  r_level[0] & r_level[1] & r_level_q[1];

endmodule

// File: rtl/sccb_target.sv
// OV7670-style SCCB responder with a 256 x 8 register file.
// Define SCCB_AUTOINC_EN to auto-increment the sub-address after each data byte.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         SCL,
  inout  wire          SDA,
  sccb_target_if.slave bus
);

  localparam logic [7:0] DEV_WR = {DEV_ADDR, OV7670_WR_ADDR[0]};
  localparam logic [7:0] DEV_RD = {DEV_ADDR, OV7670_RD_ADDR[0]};

  logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  sccb_state_t r_state, w_state_n;
  logic [3:0]  r_bit_cnt, w_bit_cnt_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [7:0]  r_ptr, w_ptr_n;
  logic [7:0]  r_tx, w_tx_n;
  logic        r_ack_en, w_ack_en_n;
  logic        r_sda_oe, w_sda_oe_n;
  logic        r_busy, w_busy_n;
  logic        w_we;
  logic [7:0]  w_byte, w_rd_byte;
  logic        r_wr_valid;
  logic [7:0]  r_wr_addr, r_wr_data, r_dbg_data;
  logic [7:0]  r_mem [NUM_REGS];

  sccb_line_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_line_cond (
    .clk        (clk),
    .reset      (reset),
    .i_lines    ({SCL, SDA}),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_mem[r_ptr];

  // bit_cnt 0..7 = data bits, 8 = waiting for the fall that opens the 9th bit,
  // 9 = inside the 9th bit (ACK slot).
  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = r_bit_cnt;
    w_shift_n   = r_shift;
    w_ptr_n     = r_ptr;
    w_tx_n      = r_tx;
    w_ack_en_n  = r_ack_en;
    w_sda_oe_n  = r_sda_oe;
    w_busy_n    = r_busy;
    w_we        = 1'b0;
    if (w_stop) begin
      w_state_n   = ST_IDLE;
      w_sda_oe_n  = 1'b0;
      w_busy_n    = 1'b0;
      w_bit_cnt_n = '0;
    end else if (w_start) begin
      w_state_n   = ST_DEV;
      w_sda_oe_n  = 1'b0;
      w_busy_n    = 1'b1;
      w_bit_cnt_n = '0;
    end else begin
      case (r_state)
        ST_DEV, ST_SUB, ST_WR: begin
          if (w_scl_rise && r_bit_cnt < 4'd8) begin
            w_shift_n   = w_byte;
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              if (r_state == ST_DEV) begin
                w_ack_en_n = (w_byte == DEV_WR) || (w_byte == DEV_RD);
              end else if (r_state == ST_SUB) begin
                w_ack_en_n = 1'b1;
                w_ptr_n    = w_byte;
              end else begin
                w_ack_en_n = 1'b1;
                w_we       = 1'b1;
`ifdef SCCB_AUTOINC_EN
                w_ptr_n    = r_ptr + 8'd1;
`endif
              end
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_sda_oe_n  = r_ack_en;
            w_bit_cnt_n = 4'd9;
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_sda_oe_n  = 1'b0;
            w_bit_cnt_n = '0;
            if (r_state == ST_DEV) begin
              if (!r_ack_en) begin
                w_state_n = ST_IGNORE;
              end else if (r_shift == DEV_RD) begin
                w_state_n  = ST_RD;
                w_tx_n     = w_rd_byte;
                w_sda_oe_n = ~w_rd_byte[7];
              end else begin
                w_state_n = ST_SUB;
              end
            end else begin
              w_state_n = ST_WR;
            end
          end
        end
        ST_RD: begin
          if (w_scl_rise) begin
            if (r_bit_cnt < 4'd8) begin
              w_bit_cnt_n = r_bit_cnt + 4'd1;
            end else if (r_bit_cnt == 4'd8) begin
              if (w_sda) begin
                w_state_n = ST_IGNORE;
              end else begin
                w_bit_cnt_n = 4'd9;
`ifdef SCCB_AUTOINC_EN
                w_ptr_n     = r_ptr + 8'd1;
`endif
              end
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt >= 4'd1 && r_bit_cnt <= 4'd7) begin
              w_tx_n     = {r_tx[6:0], r_tx[7]};
              w_sda_oe_n = ~r_tx[6];
            end else if (r_bit_cnt == 4'd8) begin
              w_sda_oe_n = 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
              w_tx_n      = w_rd_byte;
              w_sda_oe_n  = ~w_rd_byte[7];
              w_bit_cnt_n = '0;
            end
          end
        end
        ST_IDLE, ST_IGNORE: begin
          w_sda_oe_n = 1'b0;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_tx       <= '0;
      r_ack_en   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_shift    <= w_shift_n;
      r_ptr      <= w_ptr_n;
      r_tx       <= w_tx_n;
      r_ack_en   <= w_ack_en_n;
      r_sda_oe   <= w_sda_oe_n;
      r_busy     <= w_busy_n;
      r_wr_valid <= w_we;
      if (w_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
    end
  end

  // dbg read and write share an edge, so a coincident read sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem      <= '{default: '0};
      r_dbg_data <= '0;
    end else begin
      if (w_we) r_mem[r_ptr] <= w_byte;
      r_dbg_data <= r_mem[bus.dbg_addr];
    end
  end

  assign SDA          = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.dbg_data = r_dbg_data;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Bit-banged SCCB master driving sccb_target; write strobes are checked by a scoreboard monitor.
module tb_sccb_target;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic m_scl;
  logic m_sda_low;
  wire  SDA;
  int   total = 0;
  int   bad   = 0;
  int   hp    = 5000;
  wr_t  exp_q[$];

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  sccb_target_if bus ();

  sccb_target #(.DEV_ADDR(7'h21)) dut (
    .clk   (clk),
    .reset (reset),
    .SCL   (m_scl),
    .SDA   (SDA),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected actual=%0h/%0h required=none", bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {24'h0, bus.wr_addr}, {24'h0, e.addr});
          check("wr_data", {24'h0, bus.wr_data}, {24'h0, e.data});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_start();
    m_sda_low = 1'b0; #(hp/2);
    m_scl     = 1'b1; #(hp/2);
    m_sda_low = 1'b1; #(hp/2);
    m_scl     = 1'b0; #(hp/2);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #(hp/2);
    m_scl     = 1'b1; #(hp/2);
    m_sda_low = 1'b0; #(hp/2);
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; #(hp/2);
    m_scl     = 1'b1; #(hp);
    m_scl     = 1'b0; #(hp/2);
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; #(hp/2);
    m_scl     = 1'b1; #(hp/2);
    b = SDA;          #(hp/2);
    m_scl     = 1'b0; #(hp/2);
  endtask

  task automatic put_byte(input string name, input logic [7:0] v, input logic exp_ack);
    logic [7:0] s;
    logic       b;
    s = v;
    repeat (8) begin
      put_bit(s[7]);
      s = s << 1;
    end
    get_bit(b);
    check(name, {31'h0, ~b}, {31'h0, exp_ack});
  endtask

  task automatic get_byte(output logic [7:0] v, input logic nack);
    logic b;
    v = '0;
    repeat (8) begin
      get_bit(b);
      v = {v[6:0], b};
    end
    put_bit(nack);
  endtask

  task automatic dbg_chk(input string name, input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    bus.dbg_addr = a;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check(name, {24'h0, bus.dbg_data}, {24'h0, e});
  endtask

  initial begin
    logic [7:0] rd;
    reset        = 1'b1;
    m_scl        = 1'b1;
    m_sda_low    = 1'b0;
    bus.dbg_addr = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    check("rst_wr_valid", {31'h0, bus.wr_valid}, 32'h0);
    check("rst_wr_addr",  {24'h0, bus.wr_addr},  32'h0);
    check("rst_wr_data",  {24'h0, bus.wr_data},  32'h0);
    check("rst_sda",      {31'h0, SDA},          32'h1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    dbg_chk("rst_dbg", 8'h12, 8'h00);

    // 3-phase write at 100 kHz
    hp = 5000;
    bus_start();
    check("t1_busy", {31'h0, bus.busy}, 32'h1);
    exp_wr(8'h12, 8'h80);
    put_byte("t1_ack_dev",  8'h42, 1'b1);
    put_byte("t1_ack_sub",  8'h12, 1'b1);
    put_byte("t1_ack_data", 8'h80, 1'b1);
    bus_stop();
    #(hp);
    check("t1_busy_end", {31'h0, bus.busy}, 32'h0);
    dbg_chk("t1_dbg12", 8'h12, 8'h80);

    hp = 400;
    // foreign device address: no ACK
    bus_start();
    put_byte("t2_nack", 8'h60, 1'b0);
    bus_stop();
    #(hp);
    check("t2_busy_end", {31'h0, bus.busy}, 32'h0);

    // write, set pointer, read back with NA
    exp_wr(8'h3A, 8'h04);
    bus_start();
    put_byte("t3_ack_dev",  8'h42, 1'b1);
    put_byte("t3_ack_sub",  8'h3A, 1'b1);
    put_byte("t3_ack_data", 8'h04, 1'b1);
    bus_stop();
    #(hp);
    bus_start();
    put_byte("t3_ack_dev2", 8'h42, 1'b1);
    put_byte("t3_ack_sub2", 8'h3A, 1'b1);
    bus_stop();
    #(hp);
    bus_start();
    put_byte("t3_ack_rd", 8'h43, 1'b1);
    get_byte(rd, 1'b1);
    check("t3_rd_data", {24'h0, rd}, 32'h04);
    #(hp);
    check("t3_sda_rel", {31'h0, SDA}, 32'h1);
    bus_stop();
    #(hp);

    // repeated START after sub-address, then read
    exp_wr(8'h40, 8'h5C);
    bus_start();
    put_byte("t4_ack_dev",  8'h42, 1'b1);
    put_byte("t4_ack_sub",  8'h40, 1'b1);
    put_byte("t4_ack_data", 8'h5C, 1'b1);
    bus_stop();
    #(hp);
    bus_start();
    put_byte("t4_ack_dev2", 8'h42, 1'b1);
    put_byte("t4_ack_sub2", 8'h40, 1'b1);
    bus_start();
    put_byte("t4_ack_rd", 8'h43, 1'b1);
    get_byte(rd, 1'b1);
    check("t4_rd_data", {24'h0, rd}, 32'h5C);
    bus_stop();
    #(hp);

    // STOP after 4 data bits discards the byte
    exp_wr(8'h11, 8'h77);
    bus_start();
    put_byte("t5_ack_dev",  8'h42, 1'b1);
    put_byte("t5_ack_sub",  8'h11, 1'b1);
    put_byte("t5_ack_data", 8'h77, 1'b1);
    bus_stop();
    #(hp);
    bus_start();
    put_byte("t5_ack_dev2", 8'h42, 1'b1);
    put_byte("t5_ack_sub2", 8'h11, 1'b1);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    bus_stop();
    #(hp);
    check("t5_busy_end", {31'h0, bus.busy}, 32'h0);
    dbg_chk("t5_dbg11", 8'h11, 8'h77);

    // 10-unit SDA glitches with SCL high: neither START nor STOP
    @(posedge clk);
    #3 m_sda_low = 1'b1;
    #10 m_sda_low = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_glitch_start", {31'h0, bus.busy}, 32'h0);
    bus_start();
    m_scl = 1'b1;
    #(hp/2);
    @(posedge clk);
    #3 m_sda_low = 1'b0;
    #10 m_sda_low = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_glitch_stop", {31'h0, bus.busy}, 32'h1);
    m_scl = 1'b0;
    #(hp/2);
    bus_stop();
    #(hp);
    check("t5_busy_end2", {31'h0, bus.busy}, 32'h0);

    // pointer wrap / hold on consecutive data bytes
    exp_wr(8'hFF, 8'hAA);
`ifdef SCCB_AUTOINC_EN
    exp_wr(8'h00, 8'hBB);
`else
    exp_wr(8'hFF, 8'hBB);
`endif
    bus_start();
    put_byte("t6_ack_dev", 8'h42, 1'b1);
    put_byte("t6_ack_sub", 8'hFF, 1'b1);
    put_byte("t6_ack_d0",  8'hAA, 1'b1);
    put_byte("t6_ack_d1",  8'hBB, 1'b1);
    bus_stop();
    #(hp);
`ifdef SCCB_AUTOINC_EN
    dbg_chk("t6_dbgFF", 8'hFF, 8'hAA);
    dbg_chk("t6_dbg00", 8'h00, 8'hBB);
`else
    dbg_chk("t6_dbgFF", 8'hFF, 8'hBB);
    dbg_chk("t6_dbg00", 8'h00, 8'h00);
`endif

    // reset while the target is driving ACK
    bus_start();
    put_byte("t7_ack_dev", 8'h42, 1'b1);
    rd = 8'h55;
    repeat (8) begin
      put_bit(rd[7]);
      rd = rd << 1;
    end
    m_sda_low = 1'b0;
    #150;
    check("t7_ack_driven", {31'h0, SDA}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_sda_rel", {31'h0, SDA},      32'h1);
    check("t7_busy",    {31'h0, bus.busy}, 32'h0);
    m_scl = 1'b1;
    #(hp);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t7_wr_addr", {24'h0, bus.wr_addr}, 32'h0);
    dbg_chk("t7_mem_clr", 8'h12, 8'h00);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C responder that emulates the OV7670 configuration port for simulation and board-level loopback of the SCCB master path.
- Oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP, and decodes 3-phase writes and 2-phase-write + 2-phase-read transactions.
- Holds a 256 x 8 register file, drives open-drain ACK and read data on SDA, and reports every accepted register write on a strobe port.

Parameters:
- DEV_ADDR, 7'h21, 7-bit device address; write address byte 8'h42, read address byte 8'h43.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs.
- FILT_LEN, 3, consecutive equal synchronized samples required before a line level is accepted (glitch filter).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- SCL  in (tri)  1  SCCB clock from master; input only.
- SDA  inout (tri)  1  open-drain data; driven only 1'b0 or 'z.
- wr_valid  out  1  one-cycle pulse per accepted data byte write.
- wr_addr  out  8  register address of the write.
- wr_data  out  8  written value.
- dbg_addr  in  8  debug read address.
- dbg_data  out  8  reg[dbg_addr], registered, 1-cycle latency.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset values: SDA released ('z); wr_valid=0; wr_addr=0; wr_data=0; dbg_data=0; busy=0; state=IDLE; sub-address pointer=0; register file cleared to 8'h00.
- Line conditioning: SCL/SDA pass through the SYNC_STAGES synchronizer, then the FILT_LEN filter. Edge detection uses the filtered levels.
- START: filtered SDA falls while SCL is high. It is honoured in every state, including a repeated start mid-byte. The bit counter is cleared, busy=1, and the next state is DEV.
- STOP: filtered SDA rises while SCL is high. From any state it releases SDA, sets busy=0, and returns to IDLE. A partial byte is discarded; no write occurs.
- Bit timing: SDA is sampled on the SCL rising edge. Own SDA changes are made on the SCL falling edge only.
- States:
  - IDLE.
  - DEV: shift 8 bits MSB first, then DEV_ACK.
    - Byte 0x42 -> ACK, then SUB.
    - Byte 0x43 -> ACK, then RD.
    - Any other byte -> no ACK, then IGNORE.
  - SUB: shift 8 bits, ACK, load sub-address pointer, then WR.
  - WR: shift 8 bits, ACK, write reg[ptr]. Stays in WR for further bytes.
  - RD: shift out reg[ptr] MSB first. Bit 7 is driven on the falling edge after the address ACK. After bit 0, SDA is released and the master's 9th bit is sampled:
    - SDA high (NA) -> IGNORE.
    - SDA low -> next byte.
  - IGNORE: SDA released until START/STOP.
- ACK: drive SDA low from the falling edge after bit 0 until the next falling edge (one full SCL period).
- Write commit: on the SCL rising edge of the 8th data bit:
  - reg[ptr] <= byte;
  - wr_valid pulses 1 cycle with wr_addr=ptr and wr_data=byte.
- Repeated data bytes in WR rewrite the same ptr (feature disabled).
- Pointer width is 8 bits and wraps 8'hFF -> 8'h00.
- dbg port read coinciding with a write to the same address returns the old value; the new value appears on the next cycle.
- Register file is not cleared by STOP or START, only by reset.
- Reset asserted mid-transaction: immediate SDA release, all state to reset values.

Optional Feature:
- SCCB_AUTOINC_EN defined: the pointer increments (mod 256) after every written data byte and after every read byte acknowledged by the master.
- Undefined: the pointer holds; repeated writes overwrite, repeated reads return the same register.

Decomposition:
- Package sccb_pkg holds:
  - the state enum typedef;
  - OV7670_WR_ADDR=8'h42 and OV7670_RD_ADDR=8'h43;
  - the NUM_REGS=256 constant.
- Sub-module sccb_line_cond: synchronizer, glitch filter, SCL rise/fall and START/STOP detect pulses. It is instantiated once, with a shared bus for both lines.

Test Plan:
- 3-phase write 42/12/80 at 100 kHz -> three ACKs; wr_valid once with wr_addr=8'h12, wr_data=8'h80; dbg_addr=8'h12 gives 8'h80.
- Device byte 8'h60 -> no ACK (SDA 'z at 9th clock), no wr_valid, busy drops at STOP.
- Write 42/3A/04, STOP, then 2-phase 42/3A, STOP, then 43 + 8 clocks + NA -> SDA returns 8'h04; SDA released after the NA.
- Repeated START after SUB byte 8'h40, then 43 read -> reg[8'h40] returned; no write strobe.
- STOP after 4 data bits of 42/11/xx -> no wr_valid, reg[8'h11] unchanged. A 10 ns SDA glitch at SCL high does not trigger START/STOP.
- SCCB_AUTOINC_EN: 42/FF/AA/BB -> writes FF=AA, 00=BB. Without the macro: FF=BB. Reset asserted mid-ACK -> SDA 'z in the same cycle.
